pipelined_execute_unit: RTL and testbench
=========================================

// Module: pipelined_execute_unit
// PURPOSE
//  Next-generation execute stage of the PipelineProcessor: registered ALU with valid/ready handshakes.
//  Adds parametrised width, 3-bit op code, flags and an optional iterative multiplier.
//  Sits between the register-read stage and the memory stage.
//  The instruction word travels with its result so downstream stages stay aligned.
// PARAMETERS
//  DATA_W   20  operand/result width (>=4)
//  INSTR_W  20  width of propagated instruction word
// PORTS
//  clock        in   1        single clock, all logic on rising edge
//  reset        in   1        synchronous, active-high
//  flush        in   1        kill in-flight op and output register (branch taken)
//  in_valid     in   1        opA/opB/control/instruction valid
//  in_ready     out  1        unit can accept an op this cycle
//  control      in   3        op code (see BEHAVIOUR)
//  instruction  in   INSTR_W  instruction word to propagate
//  opA          in   DATA_W   operand A (Read data 1)
//  opB          in   DATA_W   operand B (Read data 2)
//  out_valid    out  1        result/flags/instructionPropagation valid
//  out_ready    in   1        downstream accepts output
//  result       out  DATA_W   ALU result
//  ulaZero      out  1        opA == opB (branch compare)
//  carry        out  1        carry-out of add / borrow of sub; 0 otherwise
//  illegal      out  1        op code not supported in this build
//  instructionPropagation out INSTR_W  instruction captured with the op
// BEHAVIOUR
//  Op codes:
//   000 add, 001 or, 010 and, 011 ~opA. These match the legacy 2-bit codes.
//   100 opA-opB, 101 xor, 110 opA<<opB[$clog2(DATA_W)-1:0], 111 mul (low DATA_W bits).
//  Reset: out_valid, result, ulaZero, carry, illegal and instructionPropagation are 0; FSM goes to IDLE; in_ready is 1.
//  Handshake: a transfer occurs when valid&&ready. All outputs hold stable while out_valid && !out_ready.
//  in_ready = (state==IDLE) && (!out_valid || out_ready). The unit takes in_valid=1 with in_ready=0 as no transfer.
//  Single-cycle ops: latency 1. On accept, the output register loads on the next edge and out_valid=1.
//   Back-to-back throughput is 1 op/cycle when out_ready=1.
//  Arithmetic: add/sub wrap modulo 2^DATA_W. carry = bit DATA_W of the extended add, or borrow (opA<opB) for sub.
//   A shift amount >= DATA_W gives 0. ulaZero is computed for every op.
//  FSM: IDLE -> MUL on accepting op 111; MUL counts DATA_W cycles (shift-add).
//   MUL -> IDLE, loading the output register on the final count. Total latency is DATA_W+1 cycles; in_ready=0 throughout MUL.
//   MUL entry requires an empty or draining output register; that is already guaranteed by the in_ready rule.
//  flush: on the next edge, out_valid=0 and the FSM returns to IDLE, abandoning any multiply. in_valid in the same cycle is ignored.
//   The data outputs are not cleared.
//  reset overrides flush. reset mid-multiply aborts it and forces reset values.
//  Simultaneous output pop and input accept in the same cycle: the new result replaces the old one with no bubble.
// CONFIGURATION
//  EXEC_MUL_EN defined: op 111 runs the iterative multiply as above; illegal is always 0.
//  EXEC_MUL_EN undefined: op 111 completes in 1 cycle with result=0, carry=0, illegal=1.
//   The MUL state and multiplier logic are not built.
// STRUCTURE
//  Shared package exec_pkg:
//   OP_* localparams (3-bit codes), EXEC_IDLE/EXEC_MUL state encodings.
//   Shared by this unit and the decode stage.
//  Sub-module exec_shift_add_mul (start, busy, done, DATA_W product), instantiated only under EXEC_MUL_EN.
//  Top: combinational ALU, FSM, and output register with handshake.
// TESTING
//  1 Reset then add 1+1, out_ready=1 -> next cycle out_valid=1, result=2, ulaZero=1, carry=0.
//  2 DATA_W=20, add 0xFFFFF+1 -> result=0, carry=1. Sub 3-5 -> result=0xFFFFE, carry=1.
//  3 Or 0xFFC00|0x00003 -> 0xFFC03. Hold out_ready=0 for 3 cycles -> outputs stable, in_ready=0.
//    Then pop and accept together -> no bubble.
//  4 EXEC_MUL_EN, mul 6*7 -> in_ready=0 for 20 cycles, then result=42 after 21 cycles.
//    Without EXEC_MUL_EN: 1 cycle later, result=0 and illegal=1.
//  5 Start mul, assert flush at cycle 5 -> out_valid stays 0, in_ready=1 next cycle.
//    Next add 2+3 -> result=5.
//  6 Reset asserted mid-multiply, including with flush -> all outputs 0 next cycle.
//    Sll 1<<25 (DATA_W=20) -> result=0.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage and the decode stage.
//   OP_*        3-bit ALU op codes (000..011 match the legacy 2-bit codes)
//   exec_state_e  execute-unit FSM encodings (EXEC_IDLE / EXEC_MUL)
package exec_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_NOT = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_SLL = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic {
    EXEC_IDLE = 1'b0,
    EXEC_MUL  = 1'b1
  } exec_state_e;

endpackage

// File: rtl/exec_shift_add_mul.sv
// Iterative shift-add multiplier, low DATA_W bits of the product.
// Built only when EXEC_MUL_EN is defined.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   abort_i        drop any multiply in progress (pipeline flush)
//   start_i        load a_i/b_i and begin; one step per cycle afterwards
//   busy_o         a multiply is in progress
//   done_o         final step this cycle; product_o is valid now
//   product_o      (a_i * b_i) mod 2^DATA_W, valid while done_o
`ifdef EXEC_MUL_EN
module exec_shift_add_mul #(
  parameter int DATA_W = 20
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              abort_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] product_o
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic              busy_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] mcand_q;
  logic [DATA_W-1:0] mplier_q;
  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] acc_d;

  // The last partial product is added combinationally so the caller can
  // capture the product on the same edge that ends the count.
  assign acc_d     = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign busy_o    = busy_q;
  assign done_o    = busy_q && (cnt_q == CNT_W'(1));
  assign product_o = acc_d;

  always_ff @(posedge clk_i) begin
    if (rst_i || abort_i) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q  <= CNT_W'(DATA_W);
    end else if (busy_q) begin
      cnt_q <= cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) busy_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (start_i) begin
      mcand_q  <= a_i;
      mplier_q <= b_i;
      acc_q    <= '0;
    end else if (busy_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
    end
  end

endmodule
`endif

// File: rtl/pipelined_execute_unit.sv
// Execute stage: registered ALU with valid/ready handshakes on both sides.
// The instruction word is captured with its operands and leaves with the
// result so later stages stay aligned.
// Build option: EXEC_MUL_EN -- op 111 runs an iterative DATA_W-cycle
// multiply; without it op 111 finishes in one cycle flagged illegal.
// Ports:
//   clock, reset   rising-edge clock, synchronous active-high reset
//   flush          kill in-flight op and the output register
//   in_valid/in_ready, control, instruction, opA, opB   input side
//   out_valid/out_ready, result, ulaZero, carry, illegal,
//   instructionPropagation                              output side
module pipelined_execute_unit
  import exec_pkg::*;
#(
  parameter int DATA_W  = 20,
  parameter int INSTR_W = 20
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         control,
  input  logic [INSTR_W-1:0] instruction,
  input  logic [DATA_W-1:0]  opA,
  input  logic [DATA_W-1:0]  opB,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  result,
  output logic               ulaZero,
  output logic               carry,
  output logic               illegal,
  output logic [INSTR_W-1:0] instructionPropagation
);

  localparam int SH_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
`ifdef EXEC_MUL_EN
  localparam logic MUL_ILLEGAL = 1'b0;
`else
  localparam logic MUL_ILLEGAL = 1'b1;
`endif

  logic               out_valid_q;
  logic [DATA_W-1:0]  result_q;
  logic               zero_q;
  logic               carry_q;
  logic               illegal_q;
  logic [INSTR_W-1:0] instr_q;

  logic [DATA_W:0]    add_ext;
  logic [SH_W-1:0]    shamt;
  logic [DATA_W-1:0]  alu_res_d;
  logic               alu_carry_d;
  logic               alu_illegal_d;
  logic               alu_zero_d;
  logic               pop;
  logic               accept;

  assign add_ext    = {1'b0, opA} + {1'b0, opB};
  assign shamt      = opB[SH_W-1:0];
  assign alu_zero_d = (opA == opB);
  assign pop        = out_valid_q && out_ready;
  // A flushed cycle never transfers, whatever in_ready says.
  assign accept     = in_valid && in_ready && !flush;

  always_comb begin
    alu_res_d     = '0;
    alu_carry_d   = 1'b0;
    alu_illegal_d = 1'b0;
    case (control)
      OP_ADD: begin
        alu_res_d   = add_ext[DATA_W-1:0];
        alu_carry_d = add_ext[DATA_W];
      end
      OP_OR:  alu_res_d = opA | opB;
      OP_AND: alu_res_d = opA & opB;
      OP_NOT: alu_res_d = ~opA;
      OP_SUB: begin
        alu_res_d   = opA - opB;
        alu_carry_d = (opA < opB);
      end
      OP_XOR: alu_res_d = opA ^ opB;
      // The shift field can encode amounts past DATA_W; those flush to 0.
      OP_SLL: alu_res_d = (32'(shamt) >= DATA_W) ? '0 : (opA << shamt);
      OP_MUL: alu_illegal_d = MUL_ILLEGAL;
      default: ;
    endcase
  end

`ifdef EXEC_MUL_EN
  exec_state_e        state_q;
  logic               is_mul;
  logic               mul_start;
  logic               mul_busy;
  logic               mul_done;
  logic [DATA_W-1:0]  mul_prod;
  logic               zero_hold_q;
  logic [INSTR_W-1:0] instr_hold_q;

  assign in_ready  = (state_q == EXEC_IDLE) && (!out_valid_q || out_ready);
  assign is_mul    = (control == OP_MUL);
  assign mul_start = accept && is_mul;

  exec_shift_add_mul #(
    .DATA_W(DATA_W)
  ) u_mul (
    .clk_i     (clock),
    .rst_i     (reset),
    .abort_i   (flush),
    .start_i   (mul_start),
    .a_i       (opA),
    .b_i       (opB),
    .busy_o    (mul_busy),
    .done_o    (mul_done),
    .product_o (mul_prod)
  );

  // Operands are gone after the accept cycle, so the compare flag and the
  // instruction word wait here until the product is ready.
  always_ff @(posedge clock) begin
    if (mul_start) begin
      zero_hold_q  <= alu_zero_d;
      instr_hold_q <= instruction;
    end
  end

  // ---- FSM and output register stage ----
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= EXEC_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      illegal_q   <= 1'b0;
      instr_q     <= '0;
    end else if (flush) begin
      state_q     <= EXEC_IDLE;
      out_valid_q <= 1'b0;
    end else begin
      if (pop) out_valid_q <= 1'b0;
      case (state_q)
        EXEC_IDLE: begin
          if (accept && is_mul) begin
            state_q <= EXEC_MUL;
          end else if (accept) begin
            out_valid_q <= 1'b1;
            result_q    <= alu_res_d;
            zero_q      <= alu_zero_d;
            carry_q     <= alu_carry_d;
            illegal_q   <= alu_illegal_d;
            instr_q     <= instruction;
          end
        end
        EXEC_MUL: begin
          if (mul_busy && mul_done) begin
            state_q     <= EXEC_IDLE;
            out_valid_q <= 1'b1;
            result_q    <= mul_prod;
            zero_q      <= zero_hold_q;
            carry_q     <= 1'b0;
            illegal_q   <= 1'b0;
            instr_q     <= instr_hold_q;
          end
        end
      endcase
    end
  end
`else
  assign in_ready = !out_valid_q || out_ready;

  // ---- output register stage ----
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      illegal_q   <= 1'b0;
      instr_q     <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else begin
      if (pop) out_valid_q <= 1'b0;
      if (accept) begin
        out_valid_q <= 1'b1;
        result_q    <= alu_res_d;
        zero_q      <= alu_zero_d;
        carry_q     <= alu_carry_d;
        illegal_q   <= alu_illegal_d;
        instr_q     <= instruction;
      end
    end
  end
`endif

  assign out_valid              = out_valid_q;
  assign result                 = result_q;
  assign ulaZero                = zero_q;
  assign carry                  = carry_q;
  assign illegal                = illegal_q;
  assign instructionPropagation = instr_q;

endmodule

// File: tb/tb_pipelined_execute_unit.sv
// Scoreboard bench for pipelined_execute_unit (DATA_W=20, INSTR_W=20).
// Works with and without EXEC_MUL_EN defined.
module tb_pipelined_execute_unit;
  import exec_pkg::*;

  localparam int W  = 20;
  localparam int IW = 20;
`ifdef EXEC_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    control = 3'b000;
  logic [IW-1:0] instruction = '0;
  logic [W-1:0]  opA = '0;
  logic [W-1:0]  opB = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  result;
  logic          ulaZero;
  logic          carry;
  logic          illegal;
  logic [IW-1:0] instructionPropagation;

  always #5 clock = ~clock;

  pipelined_execute_unit #(
    .DATA_W (W),
    .INSTR_W(IW)
  ) dut (
    .clock                 (clock),
    .reset                 (reset),
    .flush                 (flush),
    .in_valid              (in_valid),
    .in_ready              (in_ready),
    .control               (control),
    .instruction           (instruction),
    .opA                   (opA),
    .opB                   (opB),
    .out_valid             (out_valid),
    .out_ready             (out_ready),
    .result                (result),
    .ulaZero               (ulaZero),
    .carry                 (carry),
    .illegal               (illegal),
    .instructionPropagation(instructionPropagation)
  );

  typedef struct packed {
    logic [W-1:0]  res;
    logic          z;
    logic          c;
    logic          ill;
    logic [IW-1:0] ins;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  bit   rand_rdy    = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
    end
  endtask

  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic [IW-1:0] ins);
    exp_t   e;
    longint ua, ub, m, s;
    longint amt;
    ua    = longint'(a);
    ub    = longint'(b);
    m     = longint'(1) << W;
    e     = '0;
    e.z   = (a == b);
    e.ins = ins;
    case (op)
      OP_ADD: begin s = ua + ub; e.res = W'(s % m); e.c = (s >= m); end
      OP_OR:  e.res = a | b;
      OP_AND: e.res = a & b;
      OP_NOT: e.res = ~a;
      OP_SUB: begin s = ua - ub + m; e.res = W'(s % m); e.c = (ua < ub); end
      OP_XOR: e.res = a ^ b;
      OP_SLL: begin
        amt   = ub % (longint'(1) << $clog2(W));
        e.res = (amt >= W) ? '0 : W'((ua << amt) % m);
      end
      default: begin
        if (MUL_ON) e.res = W'((ua * ub) % m);
        else e.ill = 1'b1;
      end
    endcase
    return e;
  endfunction

  // Output monitor: every handshake on the output pops one expectation.
  always @(negedge clock) begin
    exp_t e;
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", 64'(result), 64'hDEAD);
      end else begin
        e = exp_q.pop_front();
        chk("result", 64'(result), 64'(e.res));
        chk("ulaZero", 64'(ulaZero), 64'(e.z));
        chk("carry", 64'(carry), 64'(e.c));
        chk("illegal", 64'(illegal), 64'(e.ill));
        chk("instr", 64'(instructionPropagation), 64'(e.ins));
      end
    end
  end

  always @(posedge clock) begin
    #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Present one op and hold it until accepted; leaves time at edge+1 after
  // the accepting edge, so consecutive calls issue back-to-back.
  task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [IW-1:0] ins, input bit track);
    bit done = 1'b0;
    control     = op;
    opA         = a;
    opB         = b;
    instruction = ins;
    in_valid    = 1'b1;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clock);
      if (in_ready && !flush) begin
        if (track) exp_q.push_back(model(op, a, b, ins));
        done = 1'b1;
      end
      @(posedge clock);
      #1;
    end
    in_valid = 1'b0;
    if (!done) chk("send_timeout", 64'd0, 64'd1);
  endtask

  // Cycles after the accepting edge until out_valid, and how many of those
  // cycles had in_ready low.
  task automatic measure(output int first, output int low);
    first = 0;
    low   = 0;
    for (int k = 1; k <= 40 && first == 0; k++) begin
      @(negedge clock);
      if (!in_ready) low++;
      if (out_valid) first = k;
      @(posedge clock);
      #1;
    end
  endtask

  task automatic count_valid(input int cycles, output int cnt);
    cnt = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clock);
      if (out_valid) cnt++;
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    int first, low, cnt;
    logic [W-1:0] ra, rb;

    repeat (3) step();
    reset = 1'b0;
    @(negedge clock);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_instr", 64'(instructionPropagation), 64'd0);
    step();

    // add 1+1, latency 1
    out_ready = 1'b1;
    send(OP_ADD, 20'd1, 20'd1, 20'h00A01, 1'b1);
    @(negedge clock);
    chk("lat1_valid", 64'(out_valid), 64'd1);
    chk("lat1_result", 64'(result), 64'd2);
    chk("lat1_zero", 64'(ulaZero), 64'd1);
    step();

    // back-to-back directed ops
    send(OP_ADD, 20'hFFFFF, 20'h00001, 20'h00A02, 1'b1);
    send(OP_SUB, 20'd3, 20'd5, 20'h00A03, 1'b1);
    send(OP_AND, 20'hF0F0F, 20'h0FF00, 20'h00A04, 1'b1);
    send(OP_NOT, 20'h12345, 20'h00000, 20'h00A05, 1'b1);
    send(OP_XOR, 20'hAAAAA, 20'h55555, 20'h00A06, 1'b1);
    send(OP_SLL, 20'h00001, 20'd3, 20'h00A07, 1'b1);
    send(OP_SLL, 20'h00001, 20'd25, 20'h00A08, 1'b1);
    send(OP_SUB, 20'd7, 20'd7, 20'h00A09, 1'b1);
    @(negedge clock);
    chk("b2b_valid", 64'(out_valid), 64'd1);
    step();
    step();

    // stall: outputs hold while out_ready is low
    out_ready = 1'b0;
    send(OP_OR, 20'hFFC00, 20'h00003, 20'h00B01, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_result", 64'(result), 64'hFFC03);
      chk("hold_instr", 64'(instructionPropagation), 64'h00B01);
      chk("hold_ready", 64'(in_ready), 64'd0);
      @(posedge clock);
      #1;
    end
    // pop and accept in the same cycle
    out_ready = 1'b1;
    send(OP_ADD, 20'd10, 20'd20, 20'h00B02, 1'b1);
    @(negedge clock);
    chk("nobubble_valid", 64'(out_valid), 64'd1);
    chk("nobubble_result", 64'(result), 64'd30);
    step();

    // multiply 6*7
    send(OP_MUL, 20'd6, 20'd7, 20'h00C01, 1'b1);
    measure(first, low);
    chk("mul_busy_cycles", 64'(low), MUL_ON ? 64'd20 : 64'd0);
    chk("mul_latency", 64'(first), MUL_ON ? 64'd21 : 64'd1);
    step();

    // flush at cycle 5 of a multiply, with an op offered in the same cycle
    out_ready = 1'b0;
    send(OP_MUL, 20'd9, 20'd9, 20'h00D01, 1'b0);
    repeat (4) step();
    flush    = 1'b1;
    in_valid = 1'b1;
    control  = OP_ADD;
    opA      = 20'd7;
    opB      = 20'd7;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clock);
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_ready", 64'(in_ready), 64'd1);
    step();
    out_ready = 1'b1;
    count_valid(25, cnt);
    chk("flush_no_output", 64'(cnt), 64'd0);
    send(OP_ADD, 20'd2, 20'd3, 20'h00D02, 1'b1);
    repeat (2) step();

    // reset together with flush in the middle of a multiply
    out_ready = 1'b0;
    send(OP_MUL, 20'd3, 20'd3, 20'h00E01, 1'b0);
    repeat (3) step();
    reset = 1'b1;
    flush = 1'b1;
    step();
    reset = 1'b0;
    flush = 1'b0;
    @(negedge clock);
    chk("rstmul_valid", 64'(out_valid), 64'd0);
    chk("rstmul_result", 64'(result), 64'd0);
    chk("rstmul_zero", 64'(ulaZero), 64'd0);
    chk("rstmul_carry", 64'(carry), 64'd0);
    chk("rstmul_illegal", 64'(illegal), 64'd0);
    chk("rstmul_instr", 64'(instructionPropagation), 64'd0);
    chk("rstmul_ready", 64'(in_ready), 64'd1);
    step();
    out_ready = 1'b1;
    count_valid(25, cnt);
    chk("rstmul_no_output", 64'(cnt), 64'd0);

    // random ops with random downstream back-pressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom_range(0, (1 << W) - 1));
      rb = ($urandom_range(0, 3) == 0) ? ra : W'($urandom_range(0, (1 << W) - 1));
      send(3'($urandom_range(0, 7)), ra, rb, IW'(32'h10000 + i), 1'b1);
    end
    rand_rdy = 1'b0;
    step();
    out_ready = 1'b1;
    for (int n = 0; n < 100 && exp_q.size() != 0; n++) step();
    chk("sb_drain", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
